// File: rtl/data_ram_if.sv
// Bus between the CPU control unit / ALU path and data_ram:
// clear request, ready, one write port and one registered read port.
interface data_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              Clear;
    logic              Ready;
    logic              Wr_en;
    logic [ADDR_W-1:0] Wr_addr;
    logic [DATA_W-1:0] Wr_data;
    logic              Rd_en;
    logic [ADDR_W-1:0] Rd_addr;
    logic [DATA_W-1:0] Rd_data;
    logic              Rd_valid;

    modport master (
        output Clear, Wr_en, Wr_addr, Wr_data, Rd_en, Rd_addr,
        input  Ready, Rd_data, Rd_valid
    );

    modport slave (
        input  Clear, Wr_en, Wr_addr, Wr_data, Rd_en, Rd_addr,
        output Ready, Rd_data, Rd_valid
    );
endinterface

// File: rtl/data_ram.sv
// Synchronous data memory for the 8-bit CPU datapath: one write port, one
// registered read port with valid strobe, and a clear sequencer that zeroes the array.
module data_ram #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic       Clk,
    input logic       Reset,
    data_ram_if.slave bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = bus.Wr_addr;
        mem_wdata  = bus.Wr_data;

        case (state_q)
            ST_CLEAR: begin
                // The sequencer owns the single write port while clearing.
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = INIT_VAL;
                if (bus.Clear) begin
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    if (clr_ptr_q == PTR_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.Clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    mem_we = bus.Wr_en;
                    if (bus.Rd_en) begin
                        rd_valid_d = 1'b1;
                        // Write-first bypass for a same-address read on the same edge.
                        if (bus.Wr_en && (bus.Wr_addr == bus.Rd_addr)) begin
                            rd_data_d = bus.Wr_data;
                        end else begin
                            rd_data_d = mem_q[bus.Rd_addr];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset; the clear sequencer initialises it instead.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.Ready    = (state_q == ST_IDLE);
    assign bus.Rd_data  = rd_data_q;
    assign bus.Rd_valid = rd_valid_q;
endmodule

// File: doc/data_ram.md
# data_ram

Parametrised synchronous data memory that replaces the single-word data register in the 8-bit CPU datapath with an addressable array of `DEPTH` words. It has one write port, one registered read port with a valid strobe, and a hardware clear sequencer. The sequencer zeroes the array after reset, or on request, without an asynchronous reset on the storage. It sits between the CPU control unit (address and enables) and the ALU/accumulator path (data).

## Interface

Parameters:
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 4: address width; `DEPTH = 2**ADDR_W` words.
- `INIT_VAL`, default 0: value written to every word by the clear sequence (`DATA_W` bits).

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Clear`  in  1  synchronous request to re-run the clear sequence.
- `Ready`  out  1  high when the memory accepts reads and writes.
- `Wr_en`  in  1  write strobe.
- `Wr_addr`  in  `ADDR_W`  write address.
- `Wr_data`  in  `DATA_W`  write data.
- `Rd_en`  in  1  read strobe.
- `Rd_addr`  in  `ADDR_W`  read address.
- `Rd_data`  out  `DATA_W`  registered read data.
- `Rd_valid`  out  1  one-cycle strobe: `Rd_data` updated this cycle.

## Operation

- The FSM has two states: CLEAR and IDLE. A clear pointer `clr_ptr` is `ADDR_W` bits wide.
- While `Reset` is asserted: state = CLEAR, `clr_ptr` = 0, `Ready` = 0, `Rd_data` = 0, `Rd_valid` = 0. The storage array itself is not reset.
- In CLEAR:
  - Each edge writes `INIT_VAL` to `mem[clr_ptr]` and increments `clr_ptr`.
  - On the edge that writes word `DEPTH-1`, the state becomes IDLE and `Ready` becomes 1.
  - `clr_ptr` wraps to 0.
- In IDLE, `Ready` = 1, with this priority per edge:
  - `Clear` = 1: go to CLEAR, `clr_ptr` = 0, `Ready` = 0. `Wr_en` and `Rd_en` in that cycle are ignored.
  - Otherwise, `Wr_en` = 1 writes `mem[Wr_addr]` = `Wr_data`.
  - Otherwise, `Rd_en` = 1 loads `Rd_data` and sets `Rd_valid` = 1 for exactly one cycle.
  - Write and read are independent and can happen in the same cycle.
- Read-during-write to the same address on the same edge is write-first: `Rd_data` = `Wr_data`. Different addresses: `Rd_data` = the old `mem[Rd_addr]`.
- While `Ready` = 0, `Wr_en` and `Rd_en` are ignored: no array change, no `Rd_valid`.
- `Clear` asserted during CLEAR restarts the sequence: `clr_ptr` = 0.
- `Rd_data` holds its last value when no read is performed. `Rd_valid` = 0 in every cycle without an accepted read.
- No out-of-range addresses exist, because `DEPTH` = 2**`ADDR_W`.

## Timing

- Clear latency:
  - After `Reset` deasserts, edges 1..`DEPTH` write words 0..`DEPTH-1`.
  - `Ready` rises after edge `DEPTH` and is high from cycle `DEPTH`.
  - A read or write can first be accepted at edge `DEPTH+1`.
- Clear request: `Ready` falls after the edge that samples `Clear` = 1. It rises again `DEPTH` edges later.
- Write latency: data is visible to a read issued on the following edge. Same-edge reads see it via the bypass.
- Read latency is 1 cycle. Address/enable sampled at edge N gives `Rd_data`/`Rd_valid` valid after edge N, and `Rd_valid` drops after edge N+1 unless another read is accepted there.
- Back-to-back reads every cycle give one word per cycle, with `Rd_valid` high continuously.
- Reset mid-operation (either state) takes effect immediately. Outputs go to their reset values and the full clear sequence reruns after deassertion.

## Test plan

Defaults for all scenarios: `DATA_W` = 8, `ADDR_W` = 4, `INIT_VAL` = 0.

1. Pulse `Reset`, then idle -> `Ready` = 0 for 16 edges, then 1. Read addresses 0..15 back-to-back -> `Rd_data` = 0x00 each, `Rd_valid` high 16 consecutive cycles, `Rd_data` held afterwards.
2. Write 0xA5 @3 and 0x5A @12, then read @3 and @12 -> 0xA5 then 0x5A, each one cycle after its read edge. Read @4 -> 0x00.
3. Same edge, write 0x3C @7 and read @7 -> `Rd_data` = 0x3C. Same edge, write 0x11 @2 and read @7 -> 0x3C, then a read @2 -> 0x11.
4. Assert `Wr_en` (0xFF @5) and `Rd_en` while `Ready` = 0 during clear -> no `Rd_valid`. After `Ready`, read @5 -> 0x00.
5. Fill all words with 0x77, pulse `Clear` together with a write of 0x99 @0 -> write ignored, `Ready` low 16 cycles. All reads -> 0x00. A second `Clear` at clear edge 8 -> `Ready` returns 16 edges after the second `Clear`.
6. Assert `Reset` at clear edge 10, release -> `Rd_data` = 0, `Rd_valid` = 0 immediately. `Ready` returns exactly 16 edges after release.
